// File: rtl/alu64_ctrl_pkg.sv
// Shared types for the two-requester ALU sequencer.
// Optional op counters are enabled with ALU64_ARB_CTRL_STATS_EN (see alu64_arb_ctrl).
package alu64_ctrl_pkg;
  localparam int W = 64;

  typedef logic [1:0] alu_op_t;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} ctrl_state_t;
  typedef logic tag_t;

  // op encodings understood by alu64bit; the sequencer never decodes them
  localparam alu_op_t OP_ADD = 2'b00;
  localparam alu_op_t OP_SUB = 2'b01;
  localparam alu_op_t OP_AND = 2'b10;
  localparam alu_op_t OP_XOR = 2'b11;

  function automatic logic [1:0] onehot2(input tag_t t);
    return t ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/alu64bit.sv
// 64-bit combinational ALU: add, subtract (a + ~b + cin), and, xor.
// Logic ops report cout=0.
module alu64bit
  import alu64_ctrl_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic [1:0]   op,
  output logic [W-1:0] s,
  output logic         cout
);
  logic [W:0] sum;

  // one adder serves both add and subtract
  always_comb begin
    sum  = '0;
    s    = '0;
    cout = 1'b0;
    case (op)
      OP_ADD: begin
        sum  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        s    = sum[W-1:0];
        cout = sum[W];
      end
      OP_SUB: begin
        sum  = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, cin};
        s    = sum[W-1:0];
        cout = sum[W];
      end
      OP_AND:  s = a & b;
      default: s = a ^ b;
    endcase
  end
endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: ptr has priority, the other requester wins otherwise.
module rr_arb2
  import alu64_ctrl_pkg::*;
(
  input  logic [1:0] req,
  input  tag_t       ptr,
  output logic [1:0] gnt,
  output tag_t       winner
);
  // winner is meaningful only when gnt is non-zero
  always_comb begin
    winner = req[ptr] ? ptr : ~ptr;
    gnt    = req[winner] ? onehot2(winner) : 2'b00;
  end
endmodule

// File: rtl/alu64_arb_ctrl.sv
// Shares one alu64bit between two requesters: round-robin accept, one-cycle
// execute from operand registers, held response, per-requester saved carry.
// Define ALU64_ARB_CTRL_STATS_EN to add per-requester 32-bit op counters.
module alu64_arb_ctrl #(
  parameter int W    = 64,
  parameter int NREQ = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ*2-1:0] req_op,
  input  logic [NREQ-1:0]   req_cin,
  input  logic [NREQ-1:0]   req_chain,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [W-1:0]      rsp_s,
  output logic              rsp_cout
`ifdef ALU64_ARB_CTRL_STATS_EN
  ,
  output logic [31:0]       op_count0,
  output logic [31:0]       op_count1
`endif
);
  import alu64_ctrl_pkg::*;

  ctrl_state_t     state, state_nxt;
  tag_t            rr_ptr, tag_r, winner;
  logic [1:0]      gnt;
  logic [NREQ-1:0] saved_carry;
  logic [W-1:0]    a_r, b_r, alu_s;
  alu_op_t         op_r;
  logic            cin_r, alu_cout, accept, rsp_hs;

  rr_arb2 u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .gnt    (gnt),
    .winner (winner)
  );

  alu64bit u_alu (
    .a    (a_r),
    .b    (b_r),
    .cin  (cin_r),
    .op   (op_r),
    .s    (alu_s),
    .cout (alu_cout)
  );

  // next state and handshakes; ready is held low while reset is asserted
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rsp_valid = '0;
    accept    = 1'b0;
    rsp_hs    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = rst_n ? gnt : 2'b00;
        accept    = |gnt;
        if (accept) state_nxt = EXEC;
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        rsp_valid = onehot2(tag_r);
        rsp_hs    = rsp_ready[tag_r];
        if (rsp_hs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // operand capture on accept, result and saved carry capture after execute
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= 1'b0;
      tag_r       <= 1'b0;
      saved_carry <= '0;
      a_r         <= '0;
      b_r         <= '0;
      op_r        <= '0;
      cin_r       <= 1'b0;
      rsp_s       <= '0;
      rsp_cout    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_r    <= req_a[int'(winner)*W +: W];
        b_r    <= req_b[int'(winner)*W +: W];
        op_r   <= req_op[int'(winner)*2 +: 2];
        cin_r  <= req_chain[winner] ? saved_carry[winner] : req_cin[winner];
        tag_r  <= winner;
        rr_ptr <= ~winner;
      end
      if (state == EXEC) begin
        rsp_s              <= alu_s;
        rsp_cout           <= alu_cout;
        saved_carry[tag_r] <= alu_cout;
      end
    end
  end

`ifdef ALU64_ARB_CTRL_STATS_EN
  // count completed response handshakes per requester, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_count0 <= '0;
      op_count1 <= '0;
    end else if (rsp_hs) begin
      if (tag_r) op_count1 <= op_count1 + 32'd1;
      else       op_count0 <= op_count0 + 32'd1;
    end
  end
`endif
endmodule
